// File: rtl/ysyx_2022040010_bus_arb.sv
// Arbitrates the IF fetch port and the MEM data port onto one shared memory request bus.
// Optional watchdog: define ARB_TIMEOUT_EN to abort REQ/RESP after TIMEOUT_CYCLES cycles.
module ysyx_2022040010_bus_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [63:0] mem_addr_i,
    input  logic [63:0] mem_wdata_i,
    input  logic [7:0]  mem_wmask_i,
    output logic [63:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        bus_valid_o,
    output logic        bus_we_o,
    output logic [63:0] bus_addr_o,
    output logic [63:0] bus_wdata_o,
    output logic [7:0]  bus_wmask_o,
    input  logic        bus_ready_i,
    input  logic        bus_rvalid_i,
    input  logic [63:0] bus_rdata_i,
    output logic [5:0]  stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e state_q;
    logic   owner_mem_q;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLim = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q;
`else
    // Parameter only matters to the watchdog; this build has none.
    assign err_o = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            if_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= '0;
            mem_done_o  <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wmask_o <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_o       <= 1'b0;
`endif
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            err_o      <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    // Holding off while a done pulse is out keeps one transaction in flight.
                    if (!if_done_o && !mem_done_o && (mem_req_i || if_req_i)) begin
                        state_q     <= StReq;
                        bus_valid_o <= 1'b1;
                        owner_mem_q <= mem_req_i;
                        if (mem_req_i) begin
                            bus_we_o    <= mem_we_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_wdata_o <= mem_wdata_i;
                            bus_wmask_o <= mem_wmask_i;
                        end else begin
                            bus_we_o    <= 1'b0;
                            bus_addr_o  <= if_addr_i;
                            bus_wdata_o <= '0;
                            bus_wmask_o <= '0;
                        end
                    end
                end
                StReq: begin
                    if (bus_ready_i) begin
                        bus_valid_o <= 1'b0;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (bus_rvalid_i) begin
                        state_q <= StIdle;
                        if (owner_mem_q) begin
                            mem_done_o  <= 1'b1;
                            mem_rdata_o <= bus_rdata_i;
                        end else begin
                            if_done_o  <= 1'b1;
                            if_rdata_o <= bus_addr_o[2] ? bus_rdata_i[63:32] : bus_rdata_i[31:0];
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef ARB_TIMEOUT_EN
            if (state_q == StIdle) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 8'd1;
                // A response landing on the limit cycle completes normally.
                if ((cnt_q + 8'd1) == TimeoutLim && !(state_q == StResp && bus_rvalid_i)) begin
                    state_q     <= StIdle;
                    bus_valid_o <= 1'b0;
                    err_o       <= 1'b1;
                    if (owner_mem_q) begin
                        mem_done_o  <= 1'b1;
                        mem_rdata_o <= '0;
                    end else begin
                        if_done_o  <= 1'b1;
                        if_rdata_o <= '0;
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        stall_o = 6'b000000;
        if (mem_req_i || (state_q != StIdle && owner_mem_q)) begin
            stall_o = 6'b011111;
        end else if ((if_req_i || (state_q != StIdle && !owner_mem_q)) && !if_done_o) begin
            stall_o = 6'b000011;
        end
    end

endmodule
